// File: rtl/vid_stream_out.sv
// vid_stream_out
// Converts an AXI4-Stream style pixel stream into a timed video interface.
// A free-running h/v raster counter generates the timing; the stream is locked
// to the raster by its start-of-frame marker and dropped back to search mode
// whenever the source starves an active pixel or its framing disagrees with
// the raster.
//
// Ports
//   PixelClk          pixel clock, all logic on the rising edge
//   aRst              asynchronous active-high reset
//   s_tdata/valid/user/last  input pixel stream (tuser = SOF, tlast = EOL)
//   s_tready          pixel accepted when s_tvalid && s_tready
//   vid_data          output pixel, zero outside accepted active pixels
//   vid_active_video  data enable
//   vid_hsync/vsync   sync outputs, asserted level set by HSYNC_POL/VSYNC_POL
//   in_sync           high while the stream is locked to the raster
//   underflow         one-cycle pulse: active pixel with no data available
//   misalign          one-cycle pulse: tuser/tlast disagree with the raster
module vid_stream_out #(
  parameter int H_ACTIVE  = 1280,
  parameter int H_FP      = 110,
  parameter int H_SYNC    = 40,
  parameter int H_BP      = 220,
  parameter int V_ACTIVE  = 720,
  parameter int V_FP      = 5,
  parameter int V_SYNC    = 5,
  parameter int V_BP      = 20,
  parameter int HSYNC_POL = 1,
  parameter int VSYNC_POL = 1
) (
  input  logic        PixelClk,
  input  logic        aRst,
  input  logic [23:0] s_tdata,
  input  logic        s_tvalid,
  output logic        s_tready,
  input  logic        s_tuser,
  input  logic        s_tlast,
  output logic [23:0] vid_data,
  output logic        vid_active_video,
  output logic        vid_hsync,
  output logic        vid_vsync,
  output logic        in_sync,
  output logic        underflow,
  output logic        misalign
);

  localparam int CW      = 16;
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] H_LAST     = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST     = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT_C    = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT_C    = CW'(V_ACTIVE);
  localparam logic [CW-1:0] H_EOL      = CW'(H_ACTIVE - 1);
  localparam logic [CW-1:0] H_SYNC_BEG = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] H_SYNC_END = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] V_SYNC_BEG = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] V_SYNC_END = CW'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic HS_ON = (HSYNC_POL != 0);
  localparam logic VS_ON = (VSYNC_POL != 0);

  typedef enum logic {
    ST_SYNC = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_h_cnt;
  logic [CW-1:0] r_v_cnt;

  logic          w_active;
  logic          w_origin;
  logic          w_line_end;
  logic          w_hs_zone;
  logic          w_vs_zone;
  logic          w_ready;
  logic          w_take;
  logic          w_underflow;
  logic          w_misalign;

  logic [23:0]   r_vid_data;
  logic          r_active;
  logic          r_hsync;
  logic          r_vsync;
  logic          r_underflow;
  logic          r_misalign;

  // Raster counters: free-running, never influenced by the stream.
  always_ff @(posedge PixelClk or posedge aRst) begin
    if (aRst) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (r_h_cnt == H_LAST) begin
      r_h_cnt <= '0;
      r_v_cnt <= (r_v_cnt == V_LAST) ? '0 : r_v_cnt + 1'b1;
    end else begin
      r_h_cnt <= r_h_cnt + 1'b1;
    end
  end

  assign w_active   = (r_h_cnt < H_ACT_C) && (r_v_cnt < V_ACT_C);
  assign w_origin   = (r_h_cnt == '0) && (r_v_cnt == '0);
  assign w_line_end = (r_h_cnt == H_EOL);
  assign w_hs_zone  = (r_h_cnt >= H_SYNC_BEG) && (r_h_cnt < H_SYNC_END);
  assign w_vs_zone  = (r_v_cnt >= V_SYNC_BEG) && (r_v_cnt < V_SYNC_END);

  always_ff @(posedge PixelClk or posedge aRst) begin
    if (aRst) r_state <= ST_SYNC;
    else      r_state <= w_state_nxt;
  end

  // Lock control. In SYNC, everything except an SOF pixel is flushed so the
  // source drains to the next frame start, which is then held until (0,0).
  // In RUN, a pixel carrying the wrong tuser is refused (not consumed) so an
  // early SOF survives to relock on the following frame.
  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b0;
    w_take      = 1'b0;
    w_underflow = 1'b0;
    w_misalign  = 1'b0;
    case (r_state)
      ST_SYNC: begin
        if (w_origin && s_tvalid && s_tuser) begin
          w_ready     = 1'b1;
          w_take      = 1'b1;
          w_state_nxt = ST_RUN;
        end else begin
          w_ready = s_tvalid && !s_tuser;
        end
      end
      ST_RUN: begin
        if (w_active) begin
          if (!s_tvalid) begin
            w_ready     = 1'b1;
            w_underflow = 1'b1;
            w_state_nxt = ST_SYNC;
          end else if (s_tuser != w_origin) begin
            w_misalign  = 1'b1;
            w_state_nxt = ST_SYNC;
          end else begin
            w_ready = 1'b1;
            w_take  = 1'b1;
            if (s_tlast != w_line_end) begin
              w_misalign  = 1'b1;
              w_state_nxt = ST_SYNC;
            end
          end
        end
      end
    endcase
  end

  // Ready is combinational, so it is masked directly while reset is held.
  assign s_tready = w_ready && !aRst;

  // Output register stage: position and accepted pixel of cycle n shown in n+1.
  always_ff @(posedge PixelClk or posedge aRst) begin
    if (aRst) begin
      r_vid_data  <= '0;
      r_active    <= 1'b0;
      r_hsync     <= ~HS_ON;
      r_vsync     <= ~VS_ON;
      r_underflow <= 1'b0;
      r_misalign  <= 1'b0;
    end else begin
      r_vid_data  <= w_take ? s_tdata : '0;
      r_active    <= w_active;
      r_hsync     <= w_hs_zone ? HS_ON : ~HS_ON;
      r_vsync     <= w_vs_zone ? VS_ON : ~VS_ON;
      r_underflow <= w_underflow;
      r_misalign  <= w_misalign;
    end
  end

  assign vid_data         = r_vid_data;
  assign vid_active_video = r_active;
  assign vid_hsync        = r_hsync;
  assign vid_vsync        = r_vsync;
  assign underflow        = r_underflow;
  assign misalign         = r_misalign;
  assign in_sync          = (r_state == ST_RUN);

endmodule

// File: tb/tb_vid_stream_out.sv
// Testbench for vid_stream_out with a small 8x6 raster (4 active x 3 lines).
module tb_vid_stream_out;
  localparam int HA = 4, HF = 1, HS = 2, HB = 1;
  localparam int VA = 3, VF = 1, VS = 1, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [23:0] s_tdata;
  logic        s_tvalid, s_tready, s_tuser, s_tlast;
  logic [23:0] vid_data;
  logic        vid_active_video, vid_hsync, vid_vsync, in_sync, underflow, misalign;

  always #5 clk = ~clk;

  vid_stream_out #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HSYNC_POL(1), .VSYNC_POL(1)
  ) dut (
    .PixelClk(clk), .aRst(rst),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .s_tuser(s_tuser), .s_tlast(s_tlast),
    .vid_data(vid_data), .vid_active_video(vid_active_video),
    .vid_hsync(vid_hsync), .vid_vsync(vid_vsync),
    .in_sync(in_sync), .underflow(underflow), .misalign(misalign)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Source program: one entry per pixel, with optional idle cycles before it.
  logic [23:0] src_d   [0:127];
  bit          src_u   [0:127];
  bit          src_l   [0:127];
  int          src_gap [0:127];
  int          src_n = 0;
  bit          go = 0;
  bit          drv_done = 0;
  bit          drv_to = 0;

  task automatic add_frame(input int base, input int tl_idx, input int tu_idx, input int gap_idx);
    for (int i = 0; i < HA * VA; i++) begin
      src_d[src_n]   = 24'(base + i);
      src_u[src_n]   = (i == 0) || (i == tu_idx);
      src_l[src_n]   = ((i % HA) == HA - 1) || (i == tl_idx);
      src_gap[src_n] = (i == gap_idx) ? 1 : 0;
      src_n++;
    end
  endtask

  // Stream driver: present each pixel until the handshake completes.
  initial begin
    bit hs;
    int wt;
    s_tvalid = 1'b0; s_tdata = '0; s_tuser = 1'b0; s_tlast = 1'b0;
    wait (go);
    @(posedge clk); #1;
    for (int i = 0; i < src_n && !drv_to; i++) begin
      if (src_gap[i] > 0) begin
        s_tvalid = 1'b0;
        repeat (src_gap[i]) begin @(posedge clk); #1; end
      end
      s_tvalid = 1'b1; s_tdata = src_d[i]; s_tuser = src_u[i]; s_tlast = src_l[i];
      hs = 0; wt = 0;
      while (!hs && !drv_to) begin
        @(negedge clk);
        hs = s_tvalid && s_tready;
        @(posedge clk); #1;
        wt++;
        if (!hs && wt > 200) drv_to = 1;
      end
    end
    s_tvalid = 1'b0; s_tuser = 1'b0; s_tlast = 1'b0; s_tdata = '0;
    drv_done = !drv_to;
  end

  // Reference model: raster position from a cycle count, plus a lock flag.
  initial begin
    logic [23:0] e_data;
    logic e_act, e_hs, e_vs, e_uf, e_ma, e_ins;
    int m_pos, h, v;
    bit m_lock, act, org, rdy, show, uf, ma, lock_n;
    e_data = '0; e_act = 0; e_hs = 0; e_vs = 0; e_uf = 0; e_ma = 0; e_ins = 0;
    m_pos = 0; m_lock = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        e_data = '0; e_act = 0; e_hs = 0; e_vs = 0; e_uf = 0; e_ma = 0; e_ins = 0;
        m_pos = 0; m_lock = 0;
      end
      chk("m.vid_data", vid_data, e_data);
      chk("m.active", vid_active_video, e_act);
      chk("m.hsync", vid_hsync, e_hs);
      chk("m.vsync", vid_vsync, e_vs);
      chk("m.in_sync", in_sync, e_ins);
      chk("m.underflow", underflow, e_uf);
      chk("m.misalign", misalign, e_ma);
      if (rst) begin
        chk("m.tready_rst", s_tready, 0);
      end else begin
        h = m_pos % HT;
        v = m_pos / HT;
        act = (h < HA) && (v < VA);
        org = (m_pos == 0);
        rdy = 0; show = 0; uf = 0; ma = 0; lock_n = m_lock;
        if (!m_lock) begin
          if (s_tvalid && s_tuser && org) begin
            rdy = 1; show = 1; lock_n = 1;
          end else begin
            rdy = s_tvalid && !s_tuser;
          end
        end else if (act) begin
          if (!s_tvalid) begin
            rdy = 1; uf = 1; lock_n = 0;
          end else if (s_tuser != org) begin
            ma = 1; lock_n = 0;
          end else begin
            rdy = 1; show = 1;
            if (s_tlast != (h == HA - 1)) begin ma = 1; lock_n = 0; end
          end
        end
        chk("m.tready", s_tready, rdy);
        e_data = show ? s_tdata : '0;
        e_act  = act;
        e_hs   = (h >= HA + HF) && (h < HA + HF + HS);
        e_vs   = (v >= VA + VF) && (v < VA + VF + VS);
        e_uf   = uf;
        e_ma   = ma;
        e_ins  = lock_n;
        m_lock = lock_n;
        m_pos  = (m_pos + 1) % FT;
      end
    end
  end

  // Frame-level observation with hand-computed totals.
  logic [23:0] cap_q[$];
  logic        first_act_v;

  task automatic frame(input string tag, input int base, input int n,
                       input int e_ins, input int e_uf, input int e_ma);
    int a, hs_n, vs_n, ins, ufn, man;
    a = 0; hs_n = 0; vs_n = 0; ins = 0; ufn = 0; man = 0;
    cap_q.delete();
    for (int i = 0; i < FT; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (i == 0) first_act_v = vid_active_video;
      a    += int'(vid_active_video);
      hs_n += int'(vid_hsync);
      vs_n += int'(vid_vsync);
      ins  += int'(in_sync);
      ufn  += int'(underflow);
      man  += int'(misalign);
      if (vid_data != '0) cap_q.push_back(vid_data);
    end
    chk({tag, ".active_cnt"}, a, 12);
    chk({tag, ".hsync_cnt"}, hs_n, 12);
    chk({tag, ".vsync_cnt"}, vs_n, 8);
    chk({tag, ".in_sync_cnt"}, ins, e_ins);
    chk({tag, ".underflow_cnt"}, ufn, e_uf);
    chk({tag, ".misalign_cnt"}, man, e_ma);
    chk({tag, ".npix"}, cap_q.size(), n);
    for (int i = 0; i < cap_q.size() && i < n; i++)
      chk({tag, ".pix"}, cap_q[i], base + i);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst0.vid_data", vid_data, 0);
    chk("rst0.active", vid_active_video, 0);
    chk("rst0.hsync", vid_hsync, 0);
    chk("rst0.vsync", vid_vsync, 0);
    chk("rst0.in_sync", in_sync, 0);
    chk("rst0.tready", s_tready, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);

    frame("idle", 0, 0, 0, 0, 0);

    add_frame(1,   -1, -1, -1);
    add_frame(21,  -1, -1,  5);
    add_frame(41,  -1, -1, -1);
    add_frame(61,   1, -1, -1);
    add_frame(81,  -1,  2, -1);
    add_frame(101, -1, -1, -1);
    add_frame(121, -1, -1, -1);
    go = 1;

    frame("wait_sof", 0, 0, 0, 0, 0);
    frame("stream", 1, 12, 48, 0, 0);
    frame("starve", 21, 5, 9, 1, 0);
    frame("relock", 41, 12, 48, 0, 0);
    frame("bad_tlast", 61, 2, 1, 0, 1);
    frame("bad_tuser", 81, 2, 2, 0, 1);
    frame("sof_held", 83, 2, 1, 0, 1);

    repeat (10) @(posedge clk);
    #1;
    chk("pre_rst.vid_data", vid_data, 106);
    chk("pre_rst.in_sync", in_sync, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst.vid_data", vid_data, 0);
    chk("mid_rst.active", vid_active_video, 0);
    chk("mid_rst.in_sync", in_sync, 0);
    chk("mid_rst.tready", s_tready, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rel.active_c0", vid_active_video, 0);
    frame("post_rst", 0, 0, 0, 0, 0);
    chk("rel.first_active", first_act_v, 1);
    frame("post_rst_lock", 121, 12, 48, 0, 0);

    chk("drv.timeout", drv_to, 0);
    chk("drv.done", drv_done, 1);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
